// File: rtl/esc_cmd_slew.sv
// esc_cmd_slew
//   Feeds the four ESC_interface instances. Per-motor speed targets from flight
//   control are captured and clamped. They are then slewed toward the targets by
//   at most MAX_STEP per write. All four commands are published together with a
//   one-cycle wrt strobe. Writes are spaced by at least one ESC PWM frame, so an
//   ESC period is never restarted early.
//
//   Ports
//     clk                                    system clock
//     rst_n                                  asynchronous active-low reset
//     vld                                    1-cycle strobe: new targets on *_spd
//     frnt_spd, bck_spd, lft_spd, rght_spd   11-bit unsigned motor targets
//     frnt_cmd, bck_cmd, lft_cmd, rght_cmd   11-bit commands to ESC SPEED inputs
//     wrt                                    1-cycle strobe, commands valid
//     busy                                   high while an update is in progress
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for frame timer expiry with a pending target change
//   UPD    | slewing one motor per cycle, idx 0..3 = frnt, bck, lft, rght
//   WRT    | publish strobe; re-arm pending if any motor has not converged
module esc_cmd_slew #(
    parameter int          FRAME_CYC = 6250,
    parameter logic [10:0] MAX_STEP  = 11'd64,
    parameter logic [10:0] MAX_SPD   = 11'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic [10:0] frnt_cmd,
    output logic [10:0] bck_cmd,
    output logic [10:0] lft_cmd,
    output logic [10:0] rght_cmd,
    output logic        wrt,
    output logic        busy
);

    localparam int          TW        = (FRAME_CYC > 2) ? $clog2(FRAME_CYC) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(FRAME_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_WRT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q;
    logic           pending_q;
    logic [10:0]    tgt_q [4];
    logic [10:0]    cmd_q [4];
    logic [10:0]    spd_in [4];

    logic           expired;
    logic           start_upd;
    logic           upd_en;
    logic           mismatch;

    logic [10:0]        sel_tgt;
    logic [10:0]        sel_cmd;
    logic signed [11:0] diff;
    logic signed [12:0] stepped;
    logic [10:0]        new_cmd;

    function automatic logic [10:0] clamp_spd(input logic [10:0] v);
        return (v > MAX_SPD) ? MAX_SPD : v;
    endfunction

    assign spd_in[0] = frnt_spd;
    assign spd_in[1] = bck_spd;
    assign spd_in[2] = lft_spd;
    assign spd_in[3] = rght_spd;

    assign frnt_cmd = cmd_q[0];
    assign bck_cmd  = cmd_q[1];
    assign lft_cmd  = cmd_q[2];
    assign rght_cmd = cmd_q[3];

    assign expired = (timer_q == TIMER_MAX);

    assign mismatch = (cmd_q[0] != tgt_q[0]) || (cmd_q[1] != tgt_q[1]) ||
                      (cmd_q[2] != tgt_q[2]) || (cmd_q[3] != tgt_q[3]);

    // Shared slew datapath: one motor per UPD cycle, selected by idx.
    assign sel_tgt = tgt_q[idx_q];
    assign sel_cmd = cmd_q[idx_q];
    assign diff    = $signed({1'b0, sel_tgt}) - $signed({1'b0, sel_cmd});

    always_comb begin
        stepped = $signed({2'b00, sel_tgt});
        if (diff > $signed({1'b0, MAX_STEP})) begin
            stepped = $signed({2'b00, sel_cmd}) + $signed({2'b00, MAX_STEP});
        end else if (diff < -$signed({1'b0, MAX_STEP})) begin
            stepped = $signed({2'b00, sel_cmd}) - $signed({2'b00, MAX_STEP});
        end
    end

    always_comb begin
        new_cmd = stepped[10:0];
        if (stepped < 13'sd0) begin
            new_cmd = 11'd0;
        end else if (stepped > $signed({2'b00, MAX_SPD})) begin
            new_cmd = MAX_SPD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_upd = 1'b0;
        upd_en    = 1'b0;
        wrt       = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (expired && pending_q) begin
                    state_d   = S_UPD;
                    idx_d     = 2'd0;
                    start_upd = 1'b1;
                end
            end
            S_UPD: begin
                busy   = 1'b1;
                upd_en = 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = S_WRT;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_WRT: begin
                busy    = 1'b1;
                wrt     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame timer saturates so a long-idle block can update immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (wrt) begin
            timer_q <= '0;
        end else if (!expired) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // A capture always wins, so targets arriving as an update starts are not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (vld) begin
            pending_q <= 1'b1;
        end else if (start_upd) begin
            pending_q <= 1'b0;
        end else if (wrt && mismatch) begin
            pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tgt_q[i] <= 11'd0;
            end
        end else if (vld) begin
            for (int i = 0; i < 4; i++) begin
                tgt_q[i] <= clamp_spd(spd_in[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cmd_q[i] <= 11'd0;
            end
        end else if (upd_en) begin
            cmd_q[idx_q] <= new_cmd;
        end
    end

endmodule

// File: tb/tb_esc_cmd_slew.sv
module tb_esc_cmd_slew;

    localparam int FC = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
    logic [10:0] frnt_cmd, bck_cmd, lft_cmd, rght_cmd;
    logic        wrt, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int step_viol = 0;
    int idle_chg = 0;
    int over_max = 0;
    logic [10:0] cmds [4];
    logic [10:0] prev [4];

    esc_cmd_slew #(.FRAME_CYC(FC)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .frnt_cmd(frnt_cmd), .bck_cmd(bck_cmd), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
        .wrt(wrt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign cmds[0] = frnt_cmd;
    assign cmds[1] = bck_cmd;
    assign cmds[2] = lft_cmd;
    assign cmds[3] = rght_cmd;

    // Passive monitor: slew-step size, changes outside busy, ceiling.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (cmds[i] != prev[i]) begin
                    if (!busy) idle_chg = idle_chg + 1;
                    if ((int'(cmds[i]) - int'(prev[i]) > 64) ||
                        (int'(cmds[i]) - int'(prev[i]) < -64)) step_viol = step_viol + 1;
                end
                if (cmds[i] > 11'd2000) over_max = over_max + 1;
            end
        end
        for (int i = 0; i < 4; i++) prev[i] = cmds[i];
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [10:0] f, input logic [10:0] b,
                        input logic [10:0] l, input logic [10:0] r);
        @(negedge clk);
        frnt_spd = f; bck_spd = b; lft_spd = l; rght_spd = r;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_wrt(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        bit f;
        f = 1'b1;
        for (int n = 0; n < 40 && f; n++) wait_wrt(FC + 10, f);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = 1'b0;
        #1;
        checks++; if ({frnt_cmd, bck_cmd, lft_cmd, rght_cmd} !== 44'd0) begin
            errors++; $display("FAIL reset_cmds: got %h expected 0", {frnt_cmd, bck_cmd, lft_cmd, rght_cmd});
        end
        checks++; if (wrt !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags: wrt=%b busy=%b expected 0 0", wrt, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FC + 10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_pending: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_first_slew();
        bit f;
        int w1;
        apply_reset();
        send(100, 100, 100, 100);
        wait_wrt(FC + 20, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL t1_wrt1: no wrt, expected one"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmds[i] !== 11'd64) begin
                errors++; $display("FAIL t1_cmd1[%0d]: got %0d expected 64", i, cmds[i]);
            end
        end
        w1 = cyc;
        wait_wrt(FC + 20, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL t1_wrt2: no wrt, expected one"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmds[i] !== 11'd100) begin
                errors++; $display("FAIL t1_cmd2[%0d]: got %0d expected 100", i, cmds[i]);
            end
        end
        checks++; if (cyc - w1 !== FC + 5) begin
            errors++; $display("FAIL t1_spacing: got %0d expected %0d", cyc - w1, FC + 5);
        end
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t1_extra_wrt: got wrt expected none"); end
    endtask

    task automatic test_ramp_down();
        bit f;
        logic [10:0] exp_v;
        apply_reset();
        send(500, 500, 500, 500);
        settle();
        checks++; if (frnt_cmd !== 11'd500 || rght_cmd !== 11'd500) begin
            errors++; $display("FAIL t2_setup: got %0d/%0d expected 500", frnt_cmd, rght_cmd);
        end
        send(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            exp_v = (k < 7) ? 11'(436 - 64 * k) : 11'd0;
            wait_wrt(FC + 20, f);
            checks++; if (f !== 1'b1) begin errors++; $display("FAIL t2_wrt%0d: no wrt, expected one", k); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cmds[i] !== exp_v) begin
                    errors++; $display("FAIL t2_cmd%0d[%0d]: got %0d expected %0d", k, i, cmds[i], exp_v);
                end
            end
        end
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t2_extra_wrt: got wrt expected none"); end
    endtask

    task automatic test_ceiling();
        bit f;
        int om;
        apply_reset();
        send(1990, 0, 0, 0);
        settle();
        checks++; if (frnt_cmd !== 11'd1990) begin
            errors++; $display("FAIL t3_setup: got %0d expected 1990", frnt_cmd);
        end
        om = over_max;
        send(2047, 0, 0, 0);
        wait_wrt(FC + 20, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL t3_wrt: no wrt, expected one"); end
        checks++; if (frnt_cmd !== 11'd2000) begin
            errors++; $display("FAIL t3_frnt: got %0d expected 2000", frnt_cmd);
        end
        checks++; if (bck_cmd !== 11'd0) begin
            errors++; $display("FAIL t3_bck: got %0d expected 0", bck_cmd);
        end
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t3_extra_wrt: got wrt expected none"); end
        checks++; if (over_max !== om) begin
            errors++; $display("FAIL t3_over_max: got %0d excursions expected 0", over_max - om);
        end
    endtask

    task automatic test_vld_during_upd();
        bit f;
        int w, sv;
        logic [10:0] exp_f [4];
        exp_f[0] = 11'd128; exp_f[1] = 11'd192; exp_f[2] = 11'd256; exp_f[3] = 11'd300;
        apply_reset();
        sv = step_viol;
        send(100, 100, 100, 100);
        wait_busy(FC + 20, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL t4_busy: busy never rose"); end
        send(300, 100, 100, 100);
        wait_wrt(20, f);
        checks++; if (f !== 1'b1 || frnt_cmd !== 11'd64 || bck_cmd !== 11'd64) begin
            errors++; $display("FAIL t4_first: wrt=%b frnt=%0d bck=%0d expected 1 64 64", f, frnt_cmd, bck_cmd);
        end
        w = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_wrt(FC + 20, f);
            checks++; if (f !== 1'b1 || frnt_cmd !== exp_f[k]) begin
                errors++; $display("FAIL t4_frnt%0d: wrt=%b got %0d expected %0d", k, f, frnt_cmd, exp_f[k]);
            end
            checks++; if (cyc - w !== FC + 5) begin
                errors++; $display("FAIL t4_spacing%0d: got %0d expected %0d", k, cyc - w, FC + 5);
            end
            checks++; if (lft_cmd !== 11'd100) begin
                errors++; $display("FAIL t4_lft%0d: got %0d expected 100", k, lft_cmd);
            end
            w = cyc;
        end
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t4_extra_wrt: got wrt expected none"); end
        checks++; if (step_viol !== sv) begin
            errors++; $display("FAIL t4_step: got %0d oversize steps expected 0", step_viol - sv);
        end
    endtask

    task automatic test_reset_mid_upd();
        bit f;
        apply_reset();
        send(100, 100, 100, 100);
        wait_busy(FC + 20, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL t5_busy: busy never rose"); end
        repeat (2) @(negedge clk);
        checks++; if (frnt_cmd !== 11'd64 || bck_cmd !== 11'd64 || lft_cmd !== 11'd0) begin
            errors++; $display("FAIL t5_pre: got %0d/%0d/%0d expected 64/64/0", frnt_cmd, bck_cmd, lft_cmd);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({frnt_cmd, bck_cmd, lft_cmd, rght_cmd} !== 44'd0) begin
            errors++; $display("FAIL t5_cmds: got %h expected 0", {frnt_cmd, bck_cmd, lft_cmd, rght_cmd});
        end
        checks++; if (busy !== 1'b0 || wrt !== 1'b0) begin
            errors++; $display("FAIL t5_flags: busy=%b wrt=%b expected 0 0", busy, wrt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t5_wrt: got wrt expected none"); end
    endtask

    task automatic test_mixed();
        bit f;
        int sv, ic;
        logic [10:0] exp_t [4][4];
        exp_t[0] = '{11'd30, 11'd64,  11'd136, 11'd50};
        exp_t[1] = '{11'd30, 11'd128, 11'd72,  11'd50};
        exp_t[2] = '{11'd30, 11'd192, 11'd8,   11'd50};
        exp_t[3] = '{11'd30, 11'd200, 11'd0,   11'd50};
        apply_reset();
        send(0, 0, 200, 50);
        settle();
        checks++; if (lft_cmd !== 11'd200 || rght_cmd !== 11'd50) begin
            errors++; $display("FAIL t6_setup: got %0d/%0d expected 200/50", lft_cmd, rght_cmd);
        end
        sv = step_viol;
        ic = idle_chg;
        send(30, 200, 0, 50);
        for (int k = 0; k < 4; k++) begin
            wait_wrt(FC + 20, f);
            checks++; if (f !== 1'b1) begin errors++; $display("FAIL t6_wrt%0d: no wrt, expected one", k); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cmds[i] !== exp_t[k][i]) begin
                    errors++; $display("FAIL t6_cmd%0d[%0d]: got %0d expected %0d", k, i, cmds[i], exp_t[k][i]);
                end
            end
        end
        wait_wrt(3 * FC, f);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL t6_extra_wrt: got wrt expected none"); end
        checks++; if (step_viol !== sv) begin
            errors++; $display("FAIL t6_step: got %0d oversize steps expected 0", step_viol - sv);
        end
        checks++; if (idle_chg !== ic) begin
            errors++; $display("FAIL t6_idle_change: got %0d changes outside busy expected 0", idle_chg - ic);
        end
    endtask

    initial begin
        test_reset();
        test_first_slew();
        test_ramp_down();
        test_ceiling();
        test_vld_during_upd();
        test_reset_mid_upd();
        test_mixed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
